serial_sub_ctrl: RTL
====================

SERIAL_SUB_CTRL -- requirements
Module: serial_sub_ctrl

Interface
REQ-001 SHALL have parameter: WIDTH, default 8, operand bit width (legal range 2..64).
REQ-002 SHALL have port: clk  input  1  single clock; all state updates on rising edge.
REQ-003 SHALL have port: rst_n  input  1  asynchronous, active-low reset.
REQ-004 SHALL have port: start  input  1  request a subtraction; accepted only when ready=1.
REQ-005 SHALL have port: op_a  input  WIDTH  minuend, sampled on accepted start.
REQ-006 SHALL have port: op_b  input  WIDTH  subtrahend, sampled on accepted start.
REQ-007 SHALL have port: borrow_in  input  1  initial borrow, sampled on accepted start.
REQ-008 SHALL have port: ready  output  1  high in IDLE only.
REQ-009 SHALL have port: busy  output  1  high in RUN only.
REQ-010 SHALL have port: done  output  1  one-cycle pulse in DONE.
REQ-011 SHALL have port: diff  output  WIDTH  result op_a - op_b - borrow_in, modulo 2^WIDTH.
REQ-012 SHALL have port: borrow_out  output  1  final borrow (1 = unsigned underflow).
REQ-013 SHALL have ports: zero, overflow  output  1 each  result flags; present only when SERIAL_SUB_FLAGS_EN is defined.

Function
REQ-014 SHALL implement FSM states IDLE, RUN, DONE.
- IDLE->RUN on start=1.
- RUN->DONE after WIDTH bit-cycles.
- DONE->IDLE unconditionally after one cycle.
REQ-015 SHALL, on accepted start, load op_a/op_b into internal shift registers, load the borrow flop with borrow_in and clear the bit counter.
REQ-016 SHALL, in RUN, process one bit per cycle, LSB first: one full-subtractor step on (a[0], b[0], borrow flop); result bit enters the internal result shift register at the MSB end, and the borrow flop takes the cell's borrow.
REQ-017 SHALL use a bit counter of $clog2(WIDTH)+1 bits, increment it once per RUN cycle, and leave RUN when it reaches WIDTH-1 with that cycle's bit processed.
REQ-018 SHALL update diff and borrow_out only on the RUN->DONE transition and hold them until the next RUN->DONE transition.
REQ-019 SHALL meet fixed latency: start accepted at edge 0 gives done=1 during the cycle after edge WIDTH, i.e. WIDTH+1 cycles, with 1 idle cycle before the next accept.
REQ-020 SHALL ignore start while busy=1 or done=1, with no effect on state, operands or outputs.
REQ-021 SHALL NOT treat a start held high as a new request in DONE; the request is accepted on the first IDLE cycle it is still high.
REQ-022 SHALL handle boundaries exactly:
- op_b > op_a gives a wrapped diff with borrow_out=1.
- op_a=op_b with borrow_in=1 gives diff all-ones and borrow_out=1.

Reset
REQ-023 SHALL, while rst_n=0 (including mid-RUN), immediately force: state=IDLE, ready=1, busy=0, done=0, diff=0, borrow_out=0, zero=0, overflow=0, counter=0, shift registers=0.
REQ-024 SHALL NOT produce a done pulse for an operation aborted by reset.

Configuration
REQ-025 SHALL, with SERIAL_SUB_FLAGS_EN defined, register at the RUN->DONE transition:
- zero = (final diff == 0).
- overflow = (a_msb != b_msb) && (diff_msb != a_msb), signed two's-complement overflow.
REQ-026 SHALL, without SERIAL_SUB_FLAGS_EN, omit the zero/overflow ports and logic; all other behaviour is identical.

Structure
REQ-027 SHALL take the state enum (IDLE/RUN/DONE) and the default WIDTH constant from shared package serial_sub_pkg.
REQ-028 SHALL instantiate exactly one existing one-bit full_subtractor cell as the datapath; all sequencing lives in serial_sub_ctrl.

Verification
REQ-029 SHALL cover reset: rst_n=0 -> ready=1, busy=0, done=0, diff=0x00, borrow_out=0.
REQ-030 SHALL cover basic subtraction: WIDTH=8, op_a=0x5A, op_b=0x13, borrow_in=0 -> done 9 cycles after accept, diff=0x47, borrow_out=0.
REQ-031 SHALL cover underflow: op_a=0x00, op_b=0x01, borrow_in=0 -> diff=0xFF, borrow_out=1; with flags: zero=0, overflow=0.
REQ-032 SHALL cover flags:
- op_a=0x80, op_b=0x01 -> diff=0x7F, borrow_out=0, overflow=1.
- op_a=0x10, op_b=0x0F, borrow_in=1 -> diff=0x00, zero=1.
REQ-033 SHALL cover start during RUN: start pulsed with new operands at bit-cycle 3 -> ignored; original result delivered unchanged.
REQ-034 SHALL cover reset mid-RUN: rst_n low at bit-cycle 4 -> immediate IDLE and zeroed outputs, no done; the next start completes normally.

Source files
------------

// File: rtl/serial_sub_pkg.sv
// serial_sub_pkg: shared FSM state encoding and default operand width for the serial subtractor.
package serial_sub_pkg;

    localparam int DEFAULT_WIDTH = 8;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

endpackage

// File: rtl/full_subtractor.sv
// full_subtractor: one-bit full subtractor cell, d = a - b - bin with borrow out.
module full_subtractor (
    input  logic a,
    input  logic b,
    input  logic bin,
    output logic d,
    output logic bout
);

    assign d    = a ^ b ^ bin;
    assign bout = (~a & b) | (~(a ^ b) & bin);

endmodule

// File: rtl/serial_sub_ctrl.sv
// serial_sub_ctrl: bit-serial subtractor, LSB first, one full_subtractor step per RUN cycle.
// Define SERIAL_SUB_FLAGS_EN to add registered zero/overflow result flags.
module serial_sub_ctrl
    import serial_sub_pkg::*;
#(
    parameter int WIDTH = DEFAULT_WIDTH
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [WIDTH-1:0] op_a,
    input  logic [WIDTH-1:0] op_b,
    input  logic             borrow_in,
    output logic             ready,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] diff,
`ifdef SERIAL_SUB_FLAGS_EN
    output logic             zero,
    output logic             overflow,
`endif
    output logic             borrow_out
);

    localparam int CW = $clog2(WIDTH) + 1;

    state_t           state, state_nxt;
    logic [WIDTH-1:0] a_sr, b_sr, r_sr, r_nxt;
    logic [CW-1:0]    cnt;
    logic             brw, d, bout, last;

    full_subtractor u_fs (
        .a    (a_sr[0]),
        .b    (b_sr[0]),
        .bin  (brw),
        .d    (d),
        .bout (bout)
    );

    assign last  = cnt == CW'(WIDTH - 1);
    assign r_nxt = WIDTH'({d, r_sr} >> 1);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= IDLE;
        else        state <= state_nxt;
    end

    always_comb begin
        state_nxt = state == IDLE ? (start ? RUN : IDLE) :
                    state == RUN  ? (last ? DONE : RUN) : IDLE;
    end

    always_comb begin
        ready = state == IDLE;
        busy  = state == RUN;
        done  = state == DONE;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            a_sr       <= '0;
            b_sr       <= '0;
            r_sr       <= '0;
            brw        <= 1'b0;
            cnt        <= '0;
            diff       <= '0;
            borrow_out <= 1'b0;
`ifdef SERIAL_SUB_FLAGS_EN
            zero       <= 1'b0;
            overflow   <= 1'b0;
`endif
        end else if (state == IDLE && start) begin
            a_sr <= op_a;
            b_sr <= op_b;
            brw  <= borrow_in;
            cnt  <= '0;
        end else if (state == RUN) begin
            a_sr <= a_sr >> 1;
            b_sr <= b_sr >> 1;
            r_sr <= r_nxt;
            brw  <= bout;
            cnt  <= cnt + CW'(1);
            if (last) begin
                diff       <= r_nxt;
                borrow_out <= bout;
`ifdef SERIAL_SUB_FLAGS_EN
                // on the last step the shift registers hold the operand MSBs
                zero       <= r_nxt == '0;
                overflow   <= (a_sr[0] ^ b_sr[0]) & (d ^ a_sr[0]);
`endif
            end
        end
    end

endmodule
